// File: rtl/uart_ir_cmd_bridge_if.sv
// Handshake bundle between UART receiver, command bridge and IR encoder.
// master = bridge side (consumes rx bytes, produces commands).
interface uart_ir_cmd_bridge_if #(
    parameter int CMD_W = 32
);
    logic [7:0]       rx_data;
    logic             rx_ready;
    logic [CMD_W-1:0] cmd;
    logic             cmd_valid;
    logic             cmd_ready;

    modport master (input rx_data, rx_ready, cmd_ready, output cmd, cmd_valid);
    modport slave  (output rx_data, rx_ready, cmd_ready, input cmd, cmd_valid);
endinterface

// File: rtl/uart_ir_cmd_bridge.sv
// UART byte -> IR command bridge: parallel key lookup, show-ahead command FIFO.
// Optional repeat-key support is built when UART_IR_REPEAT_EN is defined.
module uart_ir_cmd_bridge #(
    parameter int                         NUM_KEYS    = 4,
    parameter int                         CMD_W       = 32,
    parameter int                         DEPTH       = 4,
    parameter logic [NUM_KEYS*8-1:0]      KEY_CODES   = {8'h34, 8'h36, 8'h32, 8'h38},
    parameter logic [NUM_KEYS*CMD_W-1:0]  CMD_CODES   = {32'h9A650707, 32'h9D620707,
                                                         32'h9E610707, 32'h9F600707},
    parameter logic [7:0]                 REPEAT_CODE = 8'h2A
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_ir_cmd_bridge_if.master     bus,
    output logic [NUM_KEYS-1:0]      led,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [15:0]              miss_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      lvl_n;

    logic             hit_c;
    logic [IW-1:0]    idx_c;
    logic [CMD_W-1:0] cmd_c;

    logic             s1_vld, s1_hit;
    logic [IW-1:0]    s1_idx;
    logic [CMD_W-1:0] s1_cmd;

    logic             pop, full, push_req, wr, miss_ev, rep_ok;
    logic [CMD_W-1:0] push_cmd;

    // Descending scan so the lowest matching index is the last to assign.
    always_comb begin
        hit_c = 1'b0;
        idx_c = '0;
        cmd_c = '0;
        for (int i = NUM_KEYS-1; i >= 0; i--) begin
            if (bus.rx_data == KEY_CODES[8*i +: 8]) begin
                hit_c = 1'b1;
                idx_c = IW'(i);
                cmd_c = CMD_CODES[CMD_W*i +: CMD_W];
            end
        end
    end

`ifdef UART_IR_REPEAT_EN
    logic             s1_rep, have_last;
    logic [CMD_W-1:0] last_cmd;
    assign rep_ok   = s1_rep && have_last;
    assign push_cmd = s1_hit ? s1_cmd : last_cmd;
`else
    logic unused_repeat;
    assign unused_repeat = ^REPEAT_CODE;
    assign rep_ok   = 1'b0;
    assign push_cmd = s1_cmd;
`endif

    assign pop      = bus.cmd_valid && bus.cmd_ready;
    assign full     = (fifo_level == FULL_LVL);
    assign push_req = s1_vld && (s1_hit || rep_ok);
    assign miss_ev  = s1_vld && !s1_hit && !rep_ok;
    // A full FIFO still takes the push when the head leaves on the same edge.
    assign wr       = push_req && (!full || pop);

    always_comb begin
        lvl_n = fifo_level;
        if (wr && !pop)      lvl_n = fifo_level + 1'b1;
        else if (!wr && pop) lvl_n = fifo_level - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld        <= 1'b0;
            s1_hit        <= 1'b0;
            s1_idx        <= '0;
            s1_cmd        <= '0;
            led           <= '0;
            miss_cnt      <= '0;
            overflow      <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level    <= '0;
            bus.cmd_valid <= 1'b0;
`ifdef UART_IR_REPEAT_EN
            s1_rep        <= 1'b0;
            have_last     <= 1'b0;
            last_cmd      <= '0;
`endif
        end else begin
            s1_vld <= bus.rx_ready;
            s1_hit <= hit_c;
            s1_idx <= idx_c;
            s1_cmd <= cmd_c;
`ifdef UART_IR_REPEAT_EN
            s1_rep <= (bus.rx_data == REPEAT_CODE) && !hit_c;
            if (wr) begin
                have_last <= 1'b1;
                last_cmd  <= push_cmd;
            end
`endif
            if (s1_vld && s1_hit) led <= NUM_KEYS'(1) << s1_idx;
            if (miss_ev) begin
                led <= '0;
                if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            end
            if (push_req && !wr) overflow <= 1'b1;
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_level    <= lvl_n;
            bus.cmd_valid <= (lvl_n != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= push_cmd;
    end

    assign bus.cmd = bus.cmd_valid ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_uart_ir_cmd_bridge.sv
// Bench for uart_ir_cmd_bridge: directed steps plus random traffic against a queue model.
// Honours UART_IR_REPEAT_EN in the same way as the design.
module tb_uart_ir_cmd_bridge;
    localparam int NK = 4, CW = 32, D = 4;

    logic clk = 1'b0;
    logic rst;
    logic [NK-1:0] led;
    logic [2:0]    fifo_level;
    logic          overflow;
    logic [15:0]   miss_cnt;

    always #5 clk = ~clk;

    uart_ir_cmd_bridge_if #(.CMD_W(CW)) bus ();

    uart_ir_cmd_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .led        (led),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .miss_cnt   (miss_cnt)
    );

    logic [7:0]  keys [NK] = '{8'h38, 8'h32, 8'h36, 8'h34};
    logic [31:0] cmds [NK] = '{32'h9F600707, 32'h9E610707, 32'h9D620707, 32'h9A650707};

    // Reference model: command queue plus status, advanced once per clock.
    logic [31:0] q [$];
    int          m_miss;
    logic        m_ovf;
    logic [NK-1:0] m_led;
    logic        p_vld;
    logic [7:0]  p_byte;
    logic        m_have;
    logic [31:0] m_last;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_push(input logic [31:0] c);
        if (q.size() < D) begin
            q.push_back(c);
            m_have = 1'b1;
            m_last = c;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic cyc(input logic r, input logic rv, input logic [7:0] b, input logic cr);
        int idx;
        @(negedge clk);
        rst = r; bus.rx_ready = rv; bus.rx_data = b; bus.cmd_ready = cr;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_miss = 0; m_ovf = 1'b0; m_led = '0; p_vld = 1'b0; m_have = 1'b0;
        end else begin
            if (q.size() > 0 && cr) void'(q.pop_front());
            if (p_vld) begin
                idx = -1;
                for (int i = 0; i < NK; i++) if (idx < 0 && keys[i] == p_byte) idx = i;
                if (idx >= 0) begin
                    m_push(cmds[idx]);
                    m_led = NK'(1) << idx;
                end
`ifdef UART_IR_REPEAT_EN
                else if (p_byte == 8'h2A && m_have) m_push(m_last);
`endif
                else begin
                    m_led = '0;
                    if (m_miss < 65535) m_miss++;
                end
            end
            p_vld = rv; p_byte = b;
        end
        #1;
        chk("cmd",        bus.cmd,         (q.size() > 0) ? q[0] : 32'h0);
        chk("cmd_valid",  32'(bus.cmd_valid), 32'(q.size() > 0));
        chk("fifo_level", 32'(fifo_level), 32'(q.size()));
        chk("overflow",   32'(overflow),   32'(m_ovf));
        chk("miss_cnt",   32'(miss_cnt),   32'(m_miss));
        chk("led",        32'(led),        32'(m_led));
    endtask

    initial begin
        logic [7:0] b;
        rst = 1'b1; bus.rx_ready = 1'b0; bus.rx_data = '0; bus.cmd_ready = 1'b0;
        p_vld = 1'b0; m_miss = 0; m_ovf = 1'b0; m_led = '0; m_have = 1'b0; m_last = '0;

        cyc(1, 0, 8'h00, 0);
        cyc(1, 0, 8'h00, 0);

        // Single hit, latency and pop.
        cyc(0, 1, 8'h38, 0);
        cyc(0, 0, 8'h00, 0);
        chk("first_cmd", bus.cmd, 32'h9F600707);
        chk("first_led", 32'(led), 32'h1);
        cyc(0, 0, 8'h00, 1);
        chk("empty_cmd", bus.cmd, 32'h0);

        // Miss.
        cyc(0, 1, 8'h41, 0);
        cyc(0, 0, 8'h00, 0);
        chk("miss_one", 32'(miss_cnt), 32'd1);

        // Overflow on five hits, then ordered drain.
        foreach (keys[i]) cyc(0, 1, keys[i], 0);
        cyc(0, 1, 8'h38, 0);
        cyc(0, 0, 8'h00, 0);
        chk("ovf_level", 32'(fifo_level), 32'd4);
        chk("ovf_flag",  32'(overflow),   32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", bus.cmd, cmds[i]);
            cyc(0, 0, 8'h00, 1);
        end

        // Full FIFO, push coincides with pop.
        cyc(1, 0, 8'h00, 0);
        foreach (keys[i]) cyc(0, 1, keys[i], 0);
        cyc(0, 1, 8'h32, 0);
        cyc(0, 0, 8'h00, 1);
        chk("full_pp_level", 32'(fifo_level), 32'd4);
        chk("full_pp_ovf",   32'(overflow),   32'd0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 8'h00, 1);

        // Back-to-back strobes.
        cyc(0, 1, 8'h36, 1);
        cyc(0, 1, 8'h34, 1);
        cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 1);
        chk("b2b_led", 32'(led), 32'h8);

`ifdef UART_IR_REPEAT_EN
        cyc(1, 0, 8'h00, 0);
        cyc(0, 1, 8'h2A, 0);
        cyc(0, 1, 8'h32, 0);
        cyc(0, 1, 8'h2A, 0);
        cyc(0, 0, 8'h00, 0);
        chk("rep_miss",  32'(miss_cnt),   32'd1);
        chk("rep_level", 32'(fifo_level), 32'd2);
        chk("rep_led",   32'(led),        32'h2);
`endif

        // Reset cancels an in-flight lookup.
        cyc(0, 1, 8'h38, 0);
        cyc(1, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);
        chk("rst_cancel", 32'(bus.cmd_valid), 32'd0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    b = keys[$urandom_range(0, NK-1)];
                2:       b = 8'h2A;
                default: b = 8'($urandom);
            endcase
            cyc(($urandom_range(0, 79) == 0), $urandom_range(0, 1) != 0, b,
                $urandom_range(0, 2) != 0);
        end

        // Miss counter saturation.
        cyc(1, 0, 8'h00, 1);
        for (int n = 0; n < 65537; n++) cyc(0, 1, 8'h41, 1);
        cyc(0, 0, 8'h00, 1);
        chk("miss_sat", 32'(miss_cnt), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_ir_cmd_bridge.md
# uart_ir_cmd_bridge

Parametrised bridge between the UART receiver and the IR encoder. Each received byte is looked up in a compile-time key table. A hit pushes the mapped IR command word into a small FIFO, which drains to the encoder over a valid/ready handshake. The block replaces the hard-wired four-key decode in the top level, and adds buffering, overflow/miss reporting and generalised table size and command width.

## Interface
Parameters:
- NUM_KEYS, 4, number of table entries (≥1)
- CMD_W, 32, command word width
- DEPTH, 4, FIFO depth; power of two, ≥2
- KEY_CODES, {8'h34,8'h36,8'h32,8'h38}, NUM_KEYS×8 bits; entry i at bits [8i+7:8i] (default: idx0 '8', 1 '2', 2 '6', 3 '4')
- CMD_CODES, {32'h9A650707,32'h9D620707,32'h9E610707,32'h9F600707}, NUM_KEYS×CMD_W bits; entry i at [CMD_W·i+CMD_W-1:CMD_W·i]
- REPEAT_CODE, 8'h2A, repeat-key byte (used only with UART_IR_REPEAT_EN)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte, qualified by rx_ready
- rx_ready  in  1  one-cycle strobe: rx_data valid
- cmd  out  CMD_W  FIFO head command
- cmd_valid  out  1  FIFO not empty
- cmd_ready  in  1  encoder accepts cmd
- led  out  NUM_KEYS  one-hot index of last hit
- fifo_level  out  $clog2(DEPTH)+1  entries held
- overflow  out  1  sticky: a hit was dropped on a full FIFO
- miss_cnt  out  16  saturating count of unmapped bytes

## Operation
- Reset values: cmd=0, cmd_valid=0, led=0, fifo_level=0, overflow=0, miss_cnt=0; FIFO pointers cleared; repeat-history flag cleared.
- Stage 1 (lookup): on an edge with rx_ready=1, rx_data is compared against all KEY_CODES in parallel. The lowest matching index wins. Registered outputs: hit, idx, command.
- Stage 2 (push), on the following edge:
  - hit: write the command into the FIFO and set led to one-hot(idx).
  - miss: no write; led←0; miss_cnt increments and saturates at 16'hFFFF.
- FIFO is show-ahead:
  - cmd = mem[rd_ptr] whenever not empty; cmd = 0 when empty.
  - A pop occurs when cmd_valid && cmd_ready.
  - Pointers wrap modulo DEPTH.
- Full boundary:
  - A push into a full FIFO with no simultaneous pop is dropped and sets overflow. overflow clears only on rst.
  - A push and a pop in the same cycle while full are both accepted; fifo_level is unchanged.
- Simultaneous push and pop while empty: the push is written and fifo_level becomes 1. A pop is impossible while empty, because cmd_valid=0.
- cmd must stay stable while cmd_valid=1 and cmd_ready=0.
- rx_ready strobes on consecutive cycles are all processed; the pipeline stalls nothing.
- rst asserted mid-operation: the FIFO contents are discarded, and an in-flight stage-1 lookup is cancelled with no push.

## Timing
- Latency: rx_ready sampled at edge N → FIFO write at edge N+1 → cmd_valid=1 after edge N+1, provided the FIFO was empty.
- Throughput: one byte per clock in; one command per clock out.
- fifo_level and overflow update on the same edge as the push or pop.
- All outputs are registered, except cmd, which is the head read from registered storage.

## Configuration
- UART_IR_REPEAT_EN defined:
  - A byte equal to REPEAT_CODE that matches no table entry re-pushes the last successfully pushed command.
  - led is left unchanged.
  - If nothing has been pushed since reset, the byte counts as a miss.
  - A table match still takes priority over REPEAT_CODE.
- Not defined: REPEAT_CODE receives no special handling, and the repeat history register is not built.

## Test plan
- Reset, then byte 8'h38 → cmd=32'h9F600707, cmd_valid=1 two edges later, led=4'b0001, fifo_level=1; cmd_ready=1 → cmd_valid=0, cmd=0.
- Byte 8'h41 → no push, led=0, miss_cnt=1. Force miss_cnt to 16'hFFFF, then another miss → stays 16'hFFFF.
- cmd_ready=0, send 5 hits ('8','2','6','4','8') → fifo_level=4, overflow=1. Drain in order: 9F600707, 9E610707, 9D620707, 9A650707.
- FIFO full with cmd_ready=1, then a hit on the same cycle → push accepted, fifo_level stays 4, overflow stays 0.
- Back-to-back strobes '6','4' with cmd_ready=1 → two commands emitted in order; led ends at 4'b1000.
- With UART_IR_REPEAT_EN: 8'h2A after reset → miss_cnt=1. Then '2', then 8'h2A → two pushes of 32'h9E610707, with led=4'b0010 held.
